datacache_core: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate L1 data cache: 32 lines x 64-bit doubleword.

---
 rtl/dcache_pkg.sv | 39 +++
 rtl/dcache_array.sv | 37 +++
 rtl/datacache_core.sv | 183 ++++++++++++++++++
 tb/tb_datacache_core.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through L1 data cache.
// Geometry is fixed at 32 lines of one 64-bit doubleword each.
package dcache_pkg;

    localparam int INDEX_W  = 5;
    localparam int LINES    = 1 << INDEX_W;
    localparam int OFFSET_W = 3;
    localparam int TAG_W    = 64 - OFFSET_W - INDEX_W;
    localparam int DATA_W   = 64;
    localparam int LINE_W   = 1 + TAG_W + DATA_W;
    localparam int ENTRY_W  = TAG_W + DATA_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        REFILL = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } dc_state_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } dc_line_t;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_d,
        input logic [DATA_W-1:0] new_d,
        input logic [7:0]        mask
    );
        logic [DATA_W-1:0] m;
        for (int b = 0; b < 8; b++) begin
            m[b*8 +: 8] = mask[b] ? new_d[b*8 +: 8] : old_d[b*8 +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag+data storage for the data cache: one synchronous read port, one write port.
// Valid bits are kept outside so they can be flash-cleared.
module dcache_array
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic [ENTRY_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [ENTRY_W-1:0] wr_data
);

    logic [ENTRY_W-1:0] mem_r [LINES];
    logic [ENTRY_W-1:0] rd_data_r;

    // Storage write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Registered read, held until the next read is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_idx];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/datacache_core.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with one outstanding request.
// Loads return the full aligned doubleword; the dbg_* port exposes lookup and array updates.
module datacache_core
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [63:0]         pc,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [63:0]         req_addr,
    input  logic [63:0]         req_wdata,
    input  logic [7:0]          req_wmask,
    input  logic                invalidate,
    output logic                rsp_valid,
    output logic [63:0]         rsp_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [63:0]         mem_addr,
    output logic [63:0]         mem_wdata,
    output logic [7:0]          mem_wmask,
    input  logic                mem_ack,
    input  logic [63:0]         mem_rdata,
    output logic [63:0]         dbg_pc,
    output logic [LINE_W-1:0]   dbg_line,
    output logic                dbg_hit,
    output logic [63:0]         dbg_data,
    output logic                dbg_update,
    output logic [63:0]         dbg_update_data
);

    dc_state_t          state_r;
    logic [63:0]        pc_r;
    logic [60:0]        dw_addr_r;
    logic               we_r;
    logic [63:0]        wdata_r;
    logic [7:0]         wmask_r;
    logic [LINES-1:0]   valid_r;
    logic [63:0]        rsp_data_r;
    logic [LINE_W-1:0]  line_hold_r;

    logic               hs_s;
    logic [INDEX_W-1:0] idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic [ENTRY_W-1:0] ram_rd_s;
    dc_line_t           line_s;
    logic               in_lookup_s;
    logic               hit_s;
    logic [63:0]        merged_s;
    logic               wr_en_s;
    logic [ENTRY_W-1:0] wr_data_s;
    logic [63:0]        upd_data_s;
    logic               unused_ok_s;

    assign unused_ok_s = ^req_addr[2:0];

    assign req_ready   = (state_r == IDLE) & ~invalidate;
    assign hs_s        = req_valid & req_ready;
    assign idx_s       = dw_addr_r[INDEX_W-1:0];
    assign tag_s       = dw_addr_r[60:INDEX_W];
    assign line_s      = {valid_r[idx_s], ram_rd_s};
    assign in_lookup_s = (state_r == LOOKUP);
    assign hit_s       = in_lookup_s & line_s.valid & (line_s.tag == tag_s);
    assign merged_s    = merge_bytes(line_s.data, wdata_r, wmask_r);

    dcache_array u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (hs_s),
        .rd_idx  (req_addr[7:3]),
        .rd_data (ram_rd_s),
        .wr_en   (wr_en_s),
        .wr_idx  (idx_s),
        .wr_data (wr_data_s)
    );

    // Array write selection: store-hit merge in LOOKUP, refill on the memory ack
    always_comb begin
        wr_en_s    = 1'b0;
        wr_data_s  = '0;
        upd_data_s = 64'h0;
        case (state_r)
            LOOKUP: begin
                if (hit_s & we_r) begin
                    wr_en_s    = 1'b1;
                    wr_data_s  = {tag_s, merged_s};
                    upd_data_s = merged_s;
                end else begin
                    wr_en_s    = 1'b0;
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    wr_en_s    = 1'b1;
                    wr_data_s  = {tag_s, mem_rdata};
                    upd_data_s = mem_rdata;
                end else begin
                    wr_en_s    = 1'b0;
                end
            end
            default: begin
                wr_en_s    = 1'b0;
            end
        endcase
    end

    // Control FSM with request latches, valid bits and response data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pc_r        <= 64'h0;
            dw_addr_r   <= 61'h0;
            we_r        <= 1'b0;
            wdata_r     <= 64'h0;
            wmask_r     <= 8'h00;
            valid_r     <= '0;
            rsp_data_r  <= 64'h0;
            line_hold_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (invalidate) begin
                        valid_r <= '0;
                    end else if (req_valid) begin
                        pc_r      <= pc;
                        dw_addr_r <= req_addr[63:3];
                        we_r      <= req_we;
                        wdata_r   <= req_wdata;
                        wmask_r   <= req_wmask;
                        state_r   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    line_hold_r <= line_s;
                    if (we_r) begin
                        state_r <= WRITE;
                    end else if (hit_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        valid_r[idx_s] <= 1'b1;
                        rsp_data_r     <= mem_rdata;
                        state_r        <= RESP;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        rsp_data_r <= 64'h0;
                        state_r    <= RESP;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state; hit-path terms use the synchronous array read
    assign rsp_valid       = (hit_s & ~we_r) | (state_r == RESP);
    assign rsp_data        = (hit_s & ~we_r)     ? line_s.data :
                             (state_r == RESP)   ? rsp_data_r  : 64'h0;
    assign mem_req         = (state_r == REFILL) | (state_r == WRITE);
    assign mem_we          = (state_r == WRITE);
    assign mem_addr        = mem_req ? {dw_addr_r, 3'b000} : 64'h0;
    assign mem_wdata       = mem_we ? wdata_r : 64'h0;
    assign mem_wmask       = mem_we ? wmask_r : 8'h00;
    assign dbg_pc          = pc_r;
    assign dbg_line        = in_lookup_s ? line_s : line_hold_r;
    assign dbg_hit         = hit_s;
    assign dbg_data        = dbg_line[63:0];
    assign dbg_update      = wr_en_s;
    assign dbg_update_data = upd_data_s;

endmodule

// File: tb/tb_datacache_core.sv
// Table-driven bench for datacache_core with a response scoreboard queue
// and hand-written invalidate / reset-during-refill sequences.
module tb_datacache_core;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [63:0]  pc;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [63:0]  req_addr;
    logic [63:0]  req_wdata;
    logic [7:0]   req_wmask;
    logic         invalidate;
    logic         rsp_valid;
    logic [63:0]  rsp_data;
    logic         mem_req;
    logic         mem_we;
    logic [63:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [7:0]   mem_wmask;
    logic         mem_ack;
    logic [63:0]  mem_rdata;
    logic [63:0]  dbg_pc;
    logic [120:0] dbg_line;
    logic         dbg_hit;
    logic [63:0]  dbg_data;
    logic         dbg_update;
    logic [63:0]  dbg_update_data;

    always #5 clk = ~clk;

    datacache_core dut (
        .clk(clk), .rst_n(rst_n), .pc(pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .invalidate(invalidate), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .dbg_pc(dbg_pc), .dbg_line(dbg_line),
        .dbg_hit(dbg_hit), .dbg_data(dbg_data), .dbg_update(dbg_update),
        .dbg_update_data(dbg_update_data)
    );

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
        logic        exp_hit;
        logic [63:0] exp_upd;
        logic [63:0] exp_rsp;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb_q[$];
    vec_t        vecs[14];

    function automatic vec_t mk(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [7:0] wmask, input logic [63:0] rdata, input logic hit,
                                input logic [63:0] upd, input logic [63:0] rsp);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
        v.rdata = rdata; v.exp_hit = hit; v.exp_upd = upd; v.exp_rsp = rsp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rsp(input string name);
        logic [63:0] e;
        chk({name, "_rsp_valid"}, {127'h0, rsp_valid}, 128'h1);
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 128'h1, 128'h0);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_rsp_data"}, {64'h0, rsp_data}, {64'h0, e});
        end
    endtask

    task automatic run_vec(input vec_t v, input logic [63:0] pcv, input string name);
        int n;
        logic [63:0] held_addr;
        @(negedge clk);
        chk({name, "_req_ready"}, {127'h0, req_ready}, 128'h1);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
        req_wdata = v.wdata; req_wmask = v.wmask; pc = pcv;
        sb_q.push_back(v.exp_rsp);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk({name, "_dbg_hit"}, {127'h0, dbg_hit}, {127'h0, v.exp_hit});
        chk({name, "_dbg_pc"}, {64'h0, dbg_pc}, {64'h0, pcv});
        if (v.we && v.exp_hit) begin
            chk({name, "_upd"}, {127'h0, dbg_update}, 128'h1);
            chk({name, "_upd_data"}, {64'h0, dbg_update_data}, {64'h0, v.exp_upd});
        end else begin
            chk({name, "_no_upd"}, {127'h0, dbg_update}, 128'h0);
        end
        if (!v.we && v.exp_hit) begin
            chk({name, "_dbg_data"}, {64'h0, dbg_data}, {64'h0, v.exp_rsp});
            chk({name, "_no_mem"}, {127'h0, mem_req}, 128'h0);
            check_rsp(name);
        end else begin
            chk({name, "_no_early_rsp"}, {127'h0, rsp_valid}, 128'h0);
            n = 0;
            while (!mem_req && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!mem_req) begin
                chk({name, "_mem_req_timeout"}, 128'h0, 128'h1);
                void'(sb_q.pop_back());
                return;
            end
            chk({name, "_mem_we"}, {127'h0, mem_we}, {127'h0, v.we});
            chk({name, "_mem_addr"}, {64'h0, mem_addr}, {64'h0, v.addr[63:3], 3'b000});
            if (v.we) begin
                chk({name, "_mem_wdata"}, {64'h0, mem_wdata}, {64'h0, v.wdata});
                chk({name, "_mem_wmask"}, {120'h0, mem_wmask}, {120'h0, v.wmask});
            end
            held_addr = mem_addr;
            @(negedge clk);
            chk({name, "_mem_req_held"}, {127'h0, mem_req}, 128'h1);
            chk({name, "_mem_addr_held"}, {64'h0, mem_addr}, {64'h0, held_addr});
            mem_ack = 1'b1; mem_rdata = v.rdata;
            #1;
            if (!v.we) begin
                chk({name, "_refill_upd"}, {127'h0, dbg_update}, 128'h1);
                chk({name, "_refill_data"}, {64'h0, dbg_update_data}, {64'h0, v.rdata});
            end else begin
                chk({name, "_wr_no_upd"}, {127'h0, dbg_update}, 128'h0);
            end
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = 64'h0;
            @(negedge clk);
            check_rsp(name);
        end
        @(negedge clk);
        chk({name, "_rsp_pulse"}, {127'h0, rsp_valid}, 128'h0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; pc = 64'h0; req_valid = 1'b0; req_we = 1'b0; req_addr = 64'h0;
        req_wdata = 64'h0; req_wmask = 8'h00; invalidate = 1'b0; mem_ack = 1'b0; mem_rdata = 64'h0;

        vecs[0]  = mk(1'b0, 64'h1000, 64'h0, 8'h00, 64'h0000_0000_DEAD_BEEF, 1'b0, 64'h0, 64'h0000_0000_DEAD_BEEF);
        vecs[1]  = mk(1'b0, 64'h1004, 64'h0, 8'h00, 64'h0, 1'b1, 64'h0, 64'h0000_0000_DEAD_BEEF);
        vecs[2]  = mk(1'b1, 64'h1000, 64'h11, 8'h01, 64'h0, 1'b1, 64'h0000_0000_DEAD_BE11, 64'h0);
        vecs[3]  = mk(1'b0, 64'h1000, 64'h0, 8'h00, 64'h0, 1'b1, 64'h0, 64'h0000_0000_DEAD_BE11);
        vecs[4]  = mk(1'b1, 64'h2000, 64'h55, 8'hFF, 64'h0, 1'b0, 64'h0, 64'h0);
        vecs[5]  = mk(1'b0, 64'h2000, 64'h0, 8'h00, 64'h2222, 1'b0, 64'h0, 64'h2222);
        vecs[6]  = mk(1'b0, 64'h1100, 64'h0, 8'h00, 64'h0011_00AA, 1'b0, 64'h0, 64'h0011_00AA);
        vecs[7]  = mk(1'b0, 64'h1000, 64'h0, 8'h00, 64'h0000_0000_DEAD_BE11, 1'b0, 64'h0, 64'h0000_0000_DEAD_BE11);
        vecs[8]  = mk(1'b1, 64'h1000, 64'hFFFF, 8'h00, 64'h0, 1'b1, 64'h0000_0000_DEAD_BE11, 64'h0);
        vecs[9]  = mk(1'b1, 64'h1000, 64'hAABB_0000_0000_0000, 8'hC0, 64'h0, 1'b1, 64'hAABB_0000_DEAD_BE11, 64'h0);
        vecs[10] = mk(1'b0, 64'h1007, 64'h0, 8'h00, 64'h0, 1'b1, 64'h0, 64'hAABB_0000_DEAD_BE11);
        vecs[11] = mk(1'b0, 64'h10F8, 64'h0, 8'h00, 64'h31, 1'b0, 64'h0, 64'h31);
        vecs[12] = mk(1'b0, 64'h10FA, 64'h0, 8'h00, 64'h0, 1'b1, 64'h0, 64'h31);
        vecs[13] = mk(1'b0, 64'h1000, 64'h0, 8'h00, 64'h0, 1'b1, 64'h0, 64'hAABB_0000_DEAD_BE11);

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {127'h0, req_ready}, 128'h1);
        chk("rst_rsp_valid", {127'h0, rsp_valid}, 128'h0);
        chk("rst_mem_req", {127'h0, mem_req}, 128'h0);
        chk("rst_mem_addr", {64'h0, mem_addr}, 128'h0);
        chk("rst_dbg_update", {127'h0, dbg_update}, 128'h0);
        chk("rst_dbg_line", {7'h0, dbg_line}, 128'h0);
        chk("rst_dbg_hit", {127'h0, dbg_hit}, 128'h0);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], 64'h8000_0000 + 64'(i) * 64'd4, $sformatf("v%0d", i));
        end

        // Stray ack in IDLE must be ignored
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 64'hBAD;
        #1;
        chk("idle_ack_no_upd", {127'h0, dbg_update}, 128'h0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_no_rsp", {127'h0, rsp_valid}, 128'h0);
        chk("idle_ack_ready", {127'h0, req_ready}, 128'h1);

        // Invalidate in IDLE blocks the request and clears every line
        @(negedge clk);
        invalidate = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h1000;
        #1;
        chk("inv_req_ready", {127'h0, req_ready}, 128'h0);
        @(posedge clk); #1;
        invalidate = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("inv_no_lookup", {127'h0, dbg_hit}, 128'h0);
        chk("inv_no_rsp", {127'h0, rsp_valid}, 128'h0);
        chk("inv_no_mem", {127'h0, mem_req}, 128'h0);
        run_vec(mk(1'b0, 64'h1000, 64'h0, 8'h00, 64'h1234, 1'b0, 64'h0, 64'h1234), 64'h9000, "inv_load");

        // Reset asserted while a refill is outstanding
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h10F8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rr_mem_req_seen", {127'h0, mem_req}, 128'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_mem_req_drop", {127'h0, mem_req}, 128'h0);
        chk("rr_req_ready", {127'h0, req_ready}, 128'h1);
        chk("rr_dbg_update", {127'h0, dbg_update}, 128'h0);
        @(posedge clk); #2 rst_n = 1'b1;
        run_vec(mk(1'b0, 64'h1000, 64'h0, 8'h00, 64'h5678, 1'b0, 64'h0, 64'h5678), 64'hA000, "rr_load0");
        run_vec(mk(1'b0, 64'h10F8, 64'h0, 8'h00, 64'h9ABC, 1'b0, 64'h0, 64'h9ABC), 64'hA004, "rr_load31");

        chk("sb_drained", {96'h0, 32'(sb_q.size())}, 128'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
